fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the 5-stage pipelined RV32I core. Owns the program counter, issues requests to the synchronous instruction memory (fixed 1-cycle read latency), and buffers returned instructions in a small prefetch queue. Presents `{pc, inst}` pairs to the decode stage over a valid/ready handshake and accepts redirects (jumps/taken branches) from the execute stage.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `QUEUE_DEPTH`, 2, prefetch queue entries; power of two, ≥2
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `imem_req`  out  1  instruction memory read request this cycle
- `imem_addr`  out  32  read address, always word-aligned
- `imem_rdata`  in  32  read data, valid the cycle after `imem_req`
- `redirect_valid`  in  1  execute-stage jump/branch taken
- `redirect_target`  in  32  new PC; bits [1:0] ignored (forced to 0)
- `id_valid`  out  1  queue head holds a valid instruction
- `id_ready`  in  1  decode accepts head this cycle
- `id_pc`  out  32  PC of head instruction
- `id_inst`  out  32  head instruction; NOP (32'h0000_0013) when `id_valid`=0

## Operation
- State: `fetch_pc`, `inflight` flag (request issued last cycle), `drop` flag (in-flight response to discard), prefetch queue of `{pc, inst}`.
- Pop: `id_valid && id_ready` removes the head.
- Issue: `imem_req`=1 iff not in reset, no redirect this cycle, and `count + inflight − pop < QUEUE_DEPTH`. On issue, `imem_addr`=`fetch_pc` and `fetch_pc` ← `fetch_pc + 4` (modulo 2^32; 32'hFFFF_FFFC wraps to 0). When `imem_req`=0, `imem_addr` still shows `fetch_pc`.
- Response: in the cycle after an issue, push `{pc_of_request, imem_rdata}` unless `drop` is set or `redirect_valid`=1 in that cycle.
- Redirect (`redirect_valid`=1): highest priority. Queue flushed (count ← 0, simultaneous pop and push are void), `fetch_pc` ← `{redirect_target[31:2], 2'b00}`, no request this cycle, and an outstanding request's response is dropped. Fetch resumes at the target the next cycle.
- Back-to-back redirects: the last one wins; no request issues until a cycle without redirect.
- Full queue with `id_ready`=0: no issue; head, `id_pc`, and `id_inst` held stable; no instruction is lost or duplicated.
- Push while full cannot occur, because the issue rule reserves a slot for every in-flight request.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `id_valid`=0, `id_pc`=0, `id_inst`=32'h0000_0013, `fetch_pc`=`RESET_PC`, queue empty, `inflight`=0, `drop`=0.
- Reset mid-operation clears everything immediately (asynchronous), including in-flight responses.
- Cycle 0 is the first rising edge after reset deasserts. Request at cycle 0, push at the end of cycle 1, `id_valid`=1 in cycle 2. Request-to-decode latency is 2 cycles.
- Steady-state throughput with `id_ready`=1: one instruction per cycle for `QUEUE_DEPTH`≥2.
- Redirect penalty: redirect in cycle N, request to target in N+1, target instruction at decode in N+3.
- All outputs are registered or decoded from registered state only. There is no combinational path from `redirect_*` or `id_ready` to `id_*`. `imem_req` may depend combinationally on `redirect_valid` and `id_ready`.

## Structure
- Shared package (`define.vh`): `NOP_INST` (32'h0000_0013), `RESET_PC` default, `XLEN`=32.
- Sub-module `fetch_queue`: synchronous FIFO of width 64 and depth `QUEUE_DEPTH` with push, pop, flush, count, head outputs, and wrapping read/write pointers. Flush has priority over push and pop.
- `fetch_stage` holds the PC register, the inflight/drop flags, and the issue logic.

## Test plan
- Reset release with `id_ready`=1 and memory returning addr-as-data. Requests go to 0, 4, 8, …. `id_valid` rises at cycle 2 with `id_pc`=0 and `id_inst`=0, then one instruction per cycle.
- Hold `id_ready`=0 from cycle 2 for 5 cycles. Queue fills to 2 entries, `imem_req` drops, and the head is held at pc 0. After release, the sequence is 0, 4, 8 with no gaps or duplicates.
- Redirect to 32'h0000_0103 at cycle 6 with a request in flight. The in-flight response is dropped and the queue empties. The next request address is 32'h100, and decode sees pc 0x100 at cycle 9.
- Redirect in the same cycle as a pop and a response. The queue ends empty, the popped instruction is delivered, and the response is discarded.
- `RESET_PC`=32'hFFFF_FFF8. Decode sees pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert reset mid-stream with the queue full. All outputs return to their reset values immediately, and after release fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
// The queue entry pairs an instruction with the PC it was fetched from.
package fetch_stage_pkg;

   localparam int          XLEN             = 32;
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_queue.sv
// Small prefetch FIFO of {pc, inst} entries with wrapping pointers.
// Flush beats push and pop in the same cycle.
module fetch_queue
   import fetch_stage_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output logic [PW:0]  count,
   output fetch_entry_t head
);

   fetch_entry_t      mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, request issue to a 1-cycle imem, and
// hand-off of buffered {pc, inst} pairs to decode over valid/ready.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic          inflight;
   logic          drop;
   logic [CW-1:0] count;
   logic [CW:0]   occupancy;
   logic          pop;
   logic          push;
   logic          issue;
   fetch_entry_t  head;
   fetch_entry_t  push_entry;

   assign id_valid = (count != '0);
   assign pop      = id_valid && id_ready;

   // Every outstanding request already owns a queue slot, so a push can never overflow.
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
   assign issue     = !reset && !redirect_valid && (occupancy < (CW+1)'(QUEUE_DEPTH));

   assign push       = inflight && !drop && !redirect_valid;
   assign push_entry = '{pc: req_pc, inst: imem_rdata};

   assign imem_req  = issue;
   assign imem_addr = fetch_pc;

   assign id_pc   = id_valid ? head.pc   : '0;
   assign id_inst = id_valid ? head.inst : NOP_INST;

   fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .count     (count),
      .head      (head)
   );

   // A redirect marks anything still arriving from the old path as stale.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         inflight <= 1'b0;
         drop     <= 1'b0;
      end else begin
         inflight <= issue;
         drop     <= redirect_valid;
         if (redirect_valid) begin
            fetch_pc <= redirect_target & ~32'h3;
         end else if (issue) begin
            fetch_pc <= fetch_pc + 32'd4;
            req_pc   <= fetch_pc;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (default and wrapping RESET_PC)
// fed by addr-as-data instruction memories.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        id_ready = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;

   logic        imem_req, id_valid;
   logic [31:0] imem_addr, imem_rdata, id_pc, id_inst;

   logic        redirect_valid_b = 1'b0;
   logic [31:0] redirect_target_b = '0;
   logic        imem_req_b, id_valid_b;
   logic [31:0] imem_addr_b, imem_rdata_b, id_pc_b, id_inst_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_pc           (id_pc),
      .id_inst         (id_inst)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) dut_wrap (
      .clk             (clk),
      .reset           (reset),
      .imem_req        (imem_req_b),
      .imem_addr       (imem_addr_b),
      .imem_rdata      (imem_rdata_b),
      .redirect_valid  (redirect_valid_b),
      .redirect_target (redirect_target_b),
      .id_valid        (id_valid_b),
      .id_ready        (id_ready),
      .id_pc           (id_pc_b),
      .id_inst         (id_inst_b)
   );

   // Synchronous instruction memories that return the address as the instruction.
   always @(posedge clk) begin
      if (imem_req)   imem_rdata   <= imem_addr;
      if (imem_req_b) imem_rdata_b <= imem_addr_b;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ready, input logic rv, input logic [31:0] target);
      id_ready        = ready;
      redirect_valid  = rv;
      redirect_target = target;
      #1;
   endtask

   task automatic startReset();
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h0);
   endtask

   task automatic releaseReset();
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   initial begin
      // Reset values while reset is held
      startReset();
      repeat (2) @(posedge clk);
      #2;
      checkOutput("rst_req",    32'(imem_req),  32'h0);
      checkOutput("rst_addr",   imem_addr,      32'h0);
      checkOutput("rst_valid",  32'(id_valid),  32'h0);
      checkOutput("rst_pc",     id_pc,          32'h0);
      checkOutput("rst_inst",   id_inst,        NOP);
      checkOutput("rst_addr_b", imem_addr_b,    32'hFFFF_FFF8);

      // Streaming from reset with decode always ready
      releaseReset();
      checkOutput("c0_req",     32'(imem_req),  32'h1);
      checkOutput("c0_addr",    imem_addr,      32'h0);
      step();
      checkOutput("c1_valid",   32'(id_valid),  32'h0);
      checkOutput("c1_addr",    imem_addr,      32'h4);
      step();
      checkOutput("c2_valid",   32'(id_valid),  32'h1);
      checkOutput("c2_pc",      id_pc,          32'h0);
      checkOutput("c2_inst",    id_inst,        32'h0);
      checkOutput("c2_pc_b",    id_pc_b,        32'hFFFF_FFF8);
      step();
      checkOutput("c3_pc",      id_pc,          32'h4);
      checkOutput("c3_inst",    id_inst,        32'h4);
      checkOutput("c3_pc_b",    id_pc_b,        32'hFFFF_FFFC);
      step();
      checkOutput("c4_pc",      id_pc,          32'h8);
      checkOutput("c4_addr",    imem_addr,      32'h10);
      checkOutput("c4_pc_b",    id_pc_b,        32'h0);
      checkOutput("c4_inst_b",  id_inst_b,      32'h0);

      // Backpressure: decode stalls cycles 2..6
      startReset();
      @(posedge clk);
      releaseReset();
      step();
      step();
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("bp2_pc",     id_pc,          32'h0);
      checkOutput("bp2_req",    32'(imem_req),  32'h0);
      for (int c = 3; c <= 6; c++) begin
         step();
         checkOutput($sformatf("bp%0d_pc", c),  id_pc,         32'h0);
         checkOutput($sformatf("bp%0d_req", c), 32'(imem_req), 32'h0);
      end
      step();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("bp7_pc",     id_pc,          32'h0);
      checkOutput("bp7_req",    32'(imem_req),  32'h1);
      checkOutput("bp7_addr",   imem_addr,      32'h8);
      step();
      checkOutput("bp8_pc",     id_pc,          32'h4);
      step();
      checkOutput("bp9_pc",     id_pc,          32'h8);
      checkOutput("bp9_valid",  32'(id_valid),  32'h1);

      // Redirect at cycle 6 with a pop and a response in the same cycle
      startReset();
      @(posedge clk);
      releaseReset();
      repeat (6) step();
      applyStimulus(1'b1, 1'b1, 32'h0000_0103);
      checkOutput("rd6_req",    32'(imem_req),  32'h0);
      checkOutput("rd6_pc",     id_pc,          32'h10);
      step();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("rd7_valid",  32'(id_valid),  32'h0);
      checkOutput("rd7_req",    32'(imem_req),  32'h1);
      checkOutput("rd7_addr",   imem_addr,      32'h100);
      step();
      checkOutput("rd8_valid",  32'(id_valid),  32'h0);
      checkOutput("rd8_addr",   imem_addr,      32'h104);
      step();
      checkOutput("rd9_pc",     id_pc,          32'h100);
      checkOutput("rd9_inst",   id_inst,        32'h100);

      // Back-to-back redirects: the last target wins
      step();
      applyStimulus(1'b1, 1'b1, 32'h0000_0200);
      checkOutput("bb10_req",   32'(imem_req),  32'h0);
      checkOutput("bb10_pc",    id_pc,          32'h104);
      step();
      applyStimulus(1'b1, 1'b1, 32'h0000_0302);
      checkOutput("bb11_req",   32'(imem_req),  32'h0);
      checkOutput("bb11_valid", 32'(id_valid),  32'h0);
      step();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("bb12_addr",  imem_addr,      32'h300);
      checkOutput("bb12_req",   32'(imem_req),  32'h1);
      step();
      checkOutput("bb13_valid", 32'(id_valid),  32'h0);
      step();
      checkOutput("bb14_pc",    id_pc,          32'h300);
      checkOutput("bb14_inst",  id_inst,        32'h300);

      // Asynchronous reset with the queue full
      startReset();
      @(posedge clk);
      releaseReset();
      step();
      step();
      applyStimulus(1'b0, 1'b0, 32'h0);
      step();
      step();
      checkOutput("mr_pre_valid", 32'(id_valid), 32'h1);
      checkOutput("mr_pre_pc",    id_pc,         32'h0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mr_req",     32'(imem_req),  32'h0);
      checkOutput("mr_addr",    imem_addr,      32'h0);
      checkOutput("mr_valid",   32'(id_valid),  32'h0);
      checkOutput("mr_pc",      id_pc,          32'h0);
      checkOutput("mr_inst",    id_inst,        NOP);
      applyStimulus(1'b1, 1'b0, 32'h0);
      @(posedge clk);
      releaseReset();
      checkOutput("mr_c0_addr", imem_addr,      32'h0);
      checkOutput("mr_c0_req",  32'(imem_req),  32'h1);
      step();
      step();
      checkOutput("mr_c2_pc",   id_pc,          32'h0);
      checkOutput("mr_c2_valid", 32'(id_valid), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
